// File: rtl/tnew_hazard_pkg.sv
// Shared definitions for the Tuse/Tnew hazard tracker.
// Covers forwarding select codes, Tnew class constants and record field widths.
package tnew_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_sel_t;

  // Tnew classes, measured on entry to E
  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam int ADDR_W   = 5;
  localparam int MD_CNT_W = 4;

endpackage

// File: rtl/tnew_hazard_tracker_src_check.sv
// Hazard check for a single ID-stage source operand.
// Compares the operand against the E/M/W writer records to produce a stall request and a forward select.
module hazard_src_check
  import tnew_hazard_pkg::*;
#(
  parameter int TNEW_W = 2
) (
  input  logic              used,
  input  logic [ADDR_W-1:0] addr,
  input  logic [TNEW_W-1:0] tuse,
  input  logic              e_wr_en,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [TNEW_W-1:0] e_tnew,
  input  logic              m_wr_en,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [TNEW_W-1:0] m_tnew,
  input  logic              w_wr_en,
  input  logic [ADDR_W-1:0] w_addr,
  output logic              stall,
  output logic [1:0]        sel
);

  logic     match_e;
  logic     match_m;
  logic     match_w;
  fwd_sel_t sel_c;

  // $0 is hard-wired, so it can never match a writer
  assign match_e = e_wr_en && (e_addr == addr) && (addr != '0);
  assign match_m = m_wr_en && (m_addr == addr) && (addr != '0);
  assign match_w = w_wr_en && (w_addr == addr) && (addr != '0);

  assign stall = used && ((match_e && (e_tnew > tuse)) || (match_m && (m_tnew > tuse)));

  // A younger writer whose result is not ready blocks older ones; stall covers that case
  always_comb begin
    sel_c = FWD_GRF;
    if (used) begin
      if (match_e) begin
        sel_c = (e_tnew == '0) ? FWD_E : FWD_GRF;
      end else if (match_m) begin
        sel_c = (m_tnew == '0) ? FWD_M : FWD_GRF;
      end else if (match_w) begin
        sel_c = FWD_W;
      end
    end
  end

  assign sel = sel_c;

endmodule

// File: rtl/tnew_hazard_tracker.sv
// Producer-side Tuse/Tnew hazard tracker sitting beside the ID stage.
// Tracks writers through E/M/W, drives stall and forward selects, and owns the mult/div busy counter.
module tnew_hazard_tracker
  import tnew_hazard_pkg::*;
#(
  parameter int MD_LATENCY = 5,
  parameter int TNEW_W     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_wr_en,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_use,
  input  logic              rs_used,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [TNEW_W-1:0] rs_tuse,
  input  logic              rt_used,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [TNEW_W-1:0] rt_tuse,
  output logic              stall,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic              md_busy
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY);

  logic                e_wr_en;
  logic [ADDR_W-1:0]   e_addr;
  logic [TNEW_W-1:0]   e_tnew;
  logic                m_wr_en;
  logic [ADDR_W-1:0]   m_addr;
  logic [TNEW_W-1:0]   m_tnew;
  // W never needs its Tnew: any W match forwards
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_addr;
  logic [MD_CNT_W-1:0] md_cnt;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  hazard_src_check #(.TNEW_W(TNEW_W)) u_rs (
    .used    (rs_used),
    .addr    (rs_addr),
    .tuse    (rs_tuse),
    .e_wr_en (e_wr_en),
    .e_addr  (e_addr),
    .e_tnew  (e_tnew),
    .m_wr_en (m_wr_en),
    .m_addr  (m_addr),
    .m_tnew  (m_tnew),
    .w_wr_en (w_wr_en),
    .w_addr  (w_addr),
    .stall   (stall_rs),
    .sel     (fwd_rs_sel)
  );

  hazard_src_check #(.TNEW_W(TNEW_W)) u_rt (
    .used    (rt_used),
    .addr    (rt_addr),
    .tuse    (rt_tuse),
    .e_wr_en (e_wr_en),
    .e_addr  (e_addr),
    .e_tnew  (e_tnew),
    .m_wr_en (m_wr_en),
    .m_addr  (m_addr),
    .m_tnew  (m_tnew),
    .w_wr_en (w_wr_en),
    .w_addr  (w_addr),
    .stall   (stall_rt),
    .sel     (fwd_rt_sel)
  );

  assign md_busy  = (md_cnt != '0);
  assign stall_md = d_md_use && md_busy;
  assign stall    = stall_rs || stall_rt || stall_md;

  // Records advance every edge; a stalled ID instruction becomes a bubble in E
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e_wr_en <= 1'b0;
      e_addr  <= '0;
      e_tnew  <= '0;
      m_wr_en <= 1'b0;
      m_addr  <= '0;
      m_tnew  <= '0;
      w_wr_en <= 1'b0;
      w_addr  <= '0;
      md_cnt  <= '0;
    end else begin
      w_wr_en <= m_wr_en;
      w_addr  <= m_addr;
      m_wr_en <= e_wr_en;
      m_addr  <= e_addr;
      m_tnew  <= tnew_dec(e_tnew);
      if (stall) begin
        e_wr_en <= 1'b0;
        e_addr  <= '0;
        e_tnew  <= '0;
      end else begin
        e_wr_en <= d_wr_en && (d_wr_addr != '0);
        e_addr  <= d_wr_addr;
        e_tnew  <= d_tnew;
      end
      if (d_md_start && !stall) begin
        md_cnt <= MD_LOAD;
      end else if (md_cnt != '0) begin
        md_cnt <= md_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tnew_hazard_tracker.sv
// Randomised scoreboard bench for tnew_hazard_tracker.
// A stage-list reference model predicts each cycle's outputs; a monitor compares them on the falling edge.
module tb_tnew_hazard_tracker;

  localparam int MD_LAT = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       d_wr_en = 1'b0;
  logic [4:0] d_wr_addr = '0;
  logic [1:0] d_tnew = '0;
  logic       d_md_start = 1'b0;
  logic       d_md_use = 1'b0;
  logic       rs_used = 1'b0;
  logic [4:0] rs_addr = '0;
  logic [1:0] rs_tuse = '0;
  logic       rt_used = 1'b0;
  logic [4:0] rt_addr = '0;
  logic [1:0] rt_tuse = '0;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       md_busy;

  always #5 clk = ~clk;

  tnew_hazard_tracker #(.MD_LATENCY(MD_LAT), .TNEW_W(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_wr_en    (d_wr_en),
    .d_wr_addr  (d_wr_addr),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_use   (d_md_use),
    .rs_used    (rs_used),
    .rs_addr    (rs_addr),
    .rs_tuse    (rs_tuse),
    .rt_used    (rt_used),
    .rt_addr    (rt_addr),
    .rt_tuse    (rt_tuse),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy)
  );

  // In-flight writers, youngest first: index 0 = E, 1 = M, 2 = W
  typedef struct {
    bit valid;
    int addr;
    int tnew;
  } writer_t;

  typedef struct {
    logic       stall;
    logic [1:0] rs_sel;
    logic [1:0] rt_sel;
    logic       busy;
  } expect_t;

  writer_t pipe [3];
  int      md_left = 0;
  expect_t exp_q [$];
  int      errors = 0;
  int      checks = 0;

  function automatic bit writes(int i, int a);
    return pipe[i].valid && (pipe[i].addr == a) && (a != 0);
  endfunction

  function automatic logic src_stall(bit used, int a, int tuse);
    if (!used) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (writes(i, a) && (pipe[i].tnew > tuse)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] src_sel(bit used, int a);
    if (!used) return 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (writes(i, a)) begin
        if (i == 2 || pipe[i].tnew == 0) return 2'(i + 1);
        return 2'd0;
      end
    end
    return 2'd0;
  endfunction

  task automatic cycle_begin();
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    d_wr_en    = 1'b0;
    d_wr_addr  = '0;
    d_tnew     = '0;
    d_md_start = 1'b0;
    d_md_use   = 1'b0;
    rs_used    = 1'b0;
    rs_addr    = '0;
    rs_tuse    = '0;
    rt_used    = 1'b0;
    rt_addr    = '0;
    rt_tuse    = '0;
  endtask

  // Predict this cycle's outputs from the driven inputs, queue them, then advance the model to the next edge
  task automatic apply_stimulus();
    expect_t e;
    writer_t fresh;
    e.busy   = (md_left > 0);
    e.stall  = src_stall(rs_used, int'(rs_addr), int'(rs_tuse)) ||
               src_stall(rt_used, int'(rt_addr), int'(rt_tuse)) ||
               (d_md_use && e.busy);
    e.rs_sel = src_sel(rs_used, int'(rs_addr));
    e.rt_sel = src_sel(rt_used, int'(rt_addr));
    exp_q.push_back(e);
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0};
      md_left = 0;
    end else begin
      fresh = '{0, 0, 0};
      if (!e.stall) fresh = '{d_wr_en && (d_wr_addr != 0), int'(d_wr_addr), int'(d_tnew)};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = fresh;
      for (int i = 1; i < 3; i++) if (pipe[i].tnew > 0) pipe[i].tnew--;
      if (d_md_start && !e.stall) md_left = MD_LAT;
      else if (md_left > 0) md_left--;
    end
  endtask

  task automatic check_output(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, required);
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("stall", int'(stall), int'(e.stall));
        check_output("fwd_rs_sel", int'(fwd_rs_sel), int'(e.rs_sel));
        check_output("fwd_rt_sel", int'(fwd_rt_sel), int'(e.rt_sel));
        check_output("md_busy", int'(md_busy), int'(e.busy));
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0};

    // Reset held with a writer presented, then a load to $8
    repeat (2) begin
      cycle_begin();
      reset_n = 1'b0; d_wr_en = 1'b1; d_wr_addr = 5'd8; d_tnew = 2'd2;
      apply_stimulus();
    end
    cycle_begin(); d_wr_en = 1'b1; d_wr_addr = 5'd8; d_tnew = 2'd2; apply_stimulus();
    repeat (3) begin
      cycle_begin(); rt_used = 1'b1; rt_addr = 5'd8; rt_tuse = 2'd1; apply_stimulus();
    end

    // ALU result consumed by a branch
    cycle_begin(); d_wr_en = 1'b1; d_wr_addr = 5'd5; d_tnew = 2'd1; apply_stimulus();
    repeat (3) begin
      cycle_begin(); rs_used = 1'b1; rs_addr = 5'd5; rs_tuse = 2'd0; apply_stimulus();
    end

    // Back-to-back writers of $3, youngest must win
    repeat (2) begin
      cycle_begin(); d_wr_en = 1'b1; d_wr_addr = 5'd3; d_tnew = 2'd0; apply_stimulus();
    end
    repeat (3) begin
      cycle_begin(); rs_used = 1'b1; rs_addr = 5'd3; rt_used = 1'b1; rt_addr = 5'd3; apply_stimulus();
    end

    // Writes to $0 are ignored
    cycle_begin(); d_wr_en = 1'b1; d_wr_addr = 5'd0; d_tnew = 2'd2; apply_stimulus();
    repeat (2) begin
      cycle_begin(); rs_used = 1'b1; rs_addr = 5'd0; rs_tuse = 2'd0; apply_stimulus();
    end

    // mult then mflo until the unit frees, then a reset mid-count
    cycle_begin(); d_md_start = 1'b1; d_md_use = 1'b1; apply_stimulus();
    repeat (7) begin
      cycle_begin(); d_md_use = 1'b1; apply_stimulus();
    end
    cycle_begin(); d_md_start = 1'b1; d_md_use = 1'b1; apply_stimulus();
    repeat (2) begin cycle_begin(); apply_stimulus(); end
    cycle_begin(); reset_n = 1'b0; apply_stimulus();
    repeat (2) begin cycle_begin(); d_md_use = 1'b1; apply_stimulus(); end

    // Random traffic on a small register window so hazards are frequent
    repeat (3000) begin
      cycle_begin();
      reset_n    = ($urandom_range(0, 63) != 0);
      d_wr_en    = $urandom_range(0, 3) != 0;
      d_wr_addr  = 5'($urandom_range(0, 3));
      d_tnew     = 2'($urandom_range(0, 2));
      d_md_start = ($urandom_range(0, 9) == 0);
      d_md_use   = d_md_start || ($urandom_range(0, 5) == 0);
      rs_used    = $urandom_range(0, 1) != 0;
      rs_addr    = 5'($urandom_range(0, 3));
      rs_tuse    = 2'($urandom_range(0, 2));
      rt_used    = $urandom_range(0, 1) != 0;
      rt_addr    = 5'($urandom_range(0, 3));
      rt_tuse    = 2'($urandom_range(0, 2));
      apply_stimulus();
    end

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
